// File: rtl/ethpipe_wb_slotmap.sv
// ethpipe_wb_slotmap
//   Wishbone slave behind wb_tlc. It maps the PCIe BAR window onto the ethpipe
//   global registers and the per-channel RX slot RAMs (port A).
//   Region adr[15:13]: 0 = global registers, 1+c = slot RAM of channel c,
//   anything else acks with data 0 and ignores writes.
//
// Ports
//   clk_125, rstn         clock; asynchronous active-low reset
//   wb_*                  Wishbone slave with 16-bit data
//                         (sel[1] -> bits[7:0], sel[0] -> bits[15:8])
//   ram_addr_o/data_o/be_o/we_o   per-channel slot RAM port A, channel-packed
//   ram_q_i               per-channel read data, valid RD_LAT cycles after address
//   slot_ready_i          per-channel pulse that sets a slot status bit
//   global_counter_i      free-running 64-bit timestamp
//   global_counter_rst_o  one-cycle clear pulse for the timestamp counter
//   irq_n_o               active-low level interrupt, ~|(status & mask)
module ethpipe_wb_slotmap #(
  parameter int NCH    = 2,
  parameter int RAM_AW = 11,
  parameter int RD_LAT = 2
) (
  input  logic                    clk_125,
  input  logic                    rstn,
  input  logic [15:0]             wb_adr_i,
  input  logic [15:0]             wb_dat_i,
  input  logic [1:0]              wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic [15:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic [NCH*RAM_AW-1:0]   ram_addr_o,
  output logic [NCH*32-1:0]       ram_data_o,
  output logic [NCH*4-1:0]        ram_be_o,
  output logic [NCH-1:0]          ram_we_o,
  input  logic [NCH*32-1:0]       ram_q_i,
  input  logic [NCH-1:0]          slot_ready_i,
  input  logic [63:0]             global_counter_i,
  output logic                    global_counter_rst_o,
  output logic                    irq_n_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, ACK = 2'd2} state_t;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(RD_LAT - 1);

  state_t state_q, state_d;

  logic [NCH-1:0]              status_q, status_d;
  logic [NCH-1:0]              mask_q, mask_d;
  logic [63:0]                 snap_q, snap_d;
  logic                        cnt_rst_q, cnt_rst_d;
  logic                        irq_n_q, irq_n_d;
  logic [15:0]                 wb_dat_q, wb_dat_d;
  logic [31:0]                 hold_q, hold_d;
  logic [NCH-1:0][RAM_AW-1:0]  addr_q, addr_d;
  logic [NCH-1:0][31:0]        data_q, data_d;
  logic [NCH-1:0][3:0]         be_q, be_d;
  logic [NCH-1:0]              we_q, we_d;
  logic [CW-1:0]               lat_cnt_q, lat_cnt_d;
  logic [2:0]                  rd_ch_q, rd_ch_d;

  logic              req, is_glob, is_slot, half, rd_lo, glob_row0;
  logic [2:0]        region, chan, gidx;
  logic [RAM_AW-1:0] word;
  logic [NCH-1:0]    clr;
  logic [31:0]       q_sel;
  logic              unused_adr0;

  assign req       = wb_cyc_i & wb_stb_i;
  assign region    = wb_adr_i[15:13];
  assign is_glob   = (region == 3'd0);
  assign is_slot   = (region != 3'd0) && ({1'b0, region} <= 4'(NCH));
  assign chan      = region - 3'd1;
  assign gidx      = wb_adr_i[3:1];
  assign glob_row0 = (wb_adr_i[12:4] == 9'd0);
  assign word      = wb_adr_i[RAM_AW+1:2];
  assign half      = wb_adr_i[1];
  // Only the lower half of a slot word needs a RAM round trip; the upper half
  // is served from the hold register filled by that lower-half read.
  assign rd_lo     = req && is_slot && !wb_we_i && !half;
  assign unused_adr0 = wb_adr_i[0];

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = rd_lo ? RD_WAIT : ACK;
      RD_WAIT: begin
        if (!req)                       state_d = IDLE;
        else if (lat_cnt_q == LAT_LAST) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The read address goes out combinationally in the request cycle so the RAM
  // latency starts counting at the stb edge; the register then holds it.
  always_comb begin
    wb_ack_o   = (state_q == ACK);
    ram_addr_o = addr_q;
    if (rstn && state_q == IDLE && rd_lo) ram_addr_o = addr_d;
  end

  always_comb begin
    mask_d    = mask_q;
    snap_d    = snap_q;
    cnt_rst_d = 1'b0;
    wb_dat_d  = wb_dat_q;
    hold_d    = hold_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    we_d      = '0;
    lat_cnt_d = lat_cnt_q;
    rd_ch_d   = rd_ch_q;
    clr       = '0;
    q_sel     = '0;

    for (int c = 0; c < NCH; c++)
      if (rd_ch_q == 3'(c)) q_sel = ram_q_i[c*32 +: 32];

    case (state_q)
      IDLE: if (req) begin
        lat_cnt_d = '0;
        wb_dat_d  = 16'h0000;
        if (is_glob) begin
          if (glob_row0) begin
            case (gidx)
              3'd0: if (wb_we_i) clr = wb_dat_i[NCH-1:0] & {NCH{wb_sel_i[1]}};
                    else         wb_dat_d = 16'(status_q);
              3'd1: if (wb_we_i) begin
                      if (wb_sel_i[1]) mask_d = wb_dat_i[NCH-1:0];
                    end else wb_dat_d = 16'(mask_q);
              // Reading the low word freezes all 64 bits so the upper words
              // form a coherent snapshot.
              3'd2: if (!wb_we_i) begin
                      snap_d   = global_counter_i;
                      wb_dat_d = global_counter_i[15:0];
                    end
              3'd3: if (!wb_we_i) wb_dat_d = snap_q[31:16];
              3'd4: if (!wb_we_i) wb_dat_d = snap_q[47:32];
              3'd5: if (!wb_we_i) wb_dat_d = snap_q[63:48];
              3'd6: if (wb_we_i && wb_dat_i[0]) cnt_rst_d = 1'b1;
              default: ;
            endcase
          end
        end else if (is_slot) begin
          for (int c = 0; c < NCH; c++) begin
            if (chan == 3'(c)) begin
              if (wb_we_i) begin
                addr_d[c] = word;
                we_d[c]   = 1'b1;
                if (half) begin
                  be_d[c]   = {wb_sel_i[0], wb_sel_i[1], 2'b00};
                  data_d[c] = {wb_dat_i, 16'h0000};
                end else begin
                  be_d[c]   = {2'b00, wb_sel_i[0], wb_sel_i[1]};
                  data_d[c] = {16'h0000, wb_dat_i};
                end
              end else if (!half) begin
                addr_d[c] = word;
                rd_ch_d   = chan;
              end
            end
          end
          if (!wb_we_i) wb_dat_d = half ? hold_q[31:16] : wb_dat_q;
        end
      end
      RD_WAIT: if (req) begin
        if (lat_cnt_q == LAT_LAST) begin
          hold_d   = q_sel;
          wb_dat_d = q_sel[15:0];
        end else begin
          lat_cnt_d = lat_cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    // A fresh slot_ready wins over a W1C aimed at the same bit.
    status_d = (status_q & ~clr) | slot_ready_i;
    irq_n_d  = ~|(status_q & mask_q);
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      status_q  <= '0;
      mask_q    <= '0;
      snap_q    <= '0;
      cnt_rst_q <= 1'b0;
      irq_n_q   <= 1'b1;
      wb_dat_q  <= '0;
      hold_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      we_q      <= '0;
      lat_cnt_q <= '0;
      rd_ch_q   <= '0;
    end else begin
      status_q  <= status_d;
      mask_q    <= mask_d;
      snap_q    <= snap_d;
      cnt_rst_q <= cnt_rst_d;
      irq_n_q   <= irq_n_d;
      wb_dat_q  <= wb_dat_d;
      hold_q    <= hold_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      we_q      <= we_d;
      lat_cnt_q <= lat_cnt_d;
      rd_ch_q   <= rd_ch_d;
    end
  end

  assign wb_dat_o             = wb_dat_q;
  assign ram_data_o           = data_q;
  assign ram_be_o             = be_q;
  assign ram_we_o             = we_q;
  assign global_counter_rst_o = cnt_rst_q;
  assign irq_n_o              = irq_n_q;

endmodule

// File: tb/tb_ethpipe_wb_slotmap.sv
// tb_ethpipe_wb_slotmap
//   Self-checking bench for ethpipe_wb_slotmap (NCH=2, RAM_AW=11, RD_LAT=2).
//   A behavioural slot RAM with RD_LAT pipeline stages sits on port A; expected
//   register, RAM and interrupt values come from a small reference model.
module tb_ethpipe_wb_slotmap;
  localparam int NCH    = 2;
  localparam int RAM_AW = 11;
  localparam int RD_LAT = 2;

  logic                  clk_125 = 1'b0;
  logic                  rstn = 1'b0;
  logic [15:0]           wb_adr_i, wb_dat_i, wb_dat_o;
  logic [1:0]            wb_sel_i;
  logic                  wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [NCH*RAM_AW-1:0] ram_addr_o;
  logic [NCH*32-1:0]     ram_data_o, ram_q_i;
  logic [NCH*4-1:0]      ram_be_o;
  logic [NCH-1:0]        ram_we_o, slot_ready_i;
  logic [63:0]           global_counter_i;
  logic                  global_counter_rst_o, irq_n_o;

  int tests = 0;
  int fails = 0;

  logic [NCH-1:0]        we_snap;
  logic [NCH*RAM_AW-1:0] addr_snap;
  logic [NCH*4-1:0]      be_snap;
  logic [NCH*32-1:0]     data_snap;
  logic                  rst_snap, irq_snap;

  always #4 clk_125 = ~clk_125;

  ethpipe_wb_slotmap #(.NCH(NCH), .RAM_AW(RAM_AW), .RD_LAT(RD_LAT)) dut (
    .clk_125(clk_125), .rstn(rstn),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_be_o(ram_be_o),
    .ram_we_o(ram_we_o), .ram_q_i(ram_q_i), .slot_ready_i(slot_ready_i),
    .global_counter_i(global_counter_i),
    .global_counter_rst_o(global_counter_rst_o), .irq_n_o(irq_n_o)
  );

  // Behavioural slot RAM: synchronous read with RD_LAT stages, byte-enabled write.
  logic [31:0] mem  [NCH][2**RAM_AW];
  logic [31:0] pipe [NCH][RD_LAT];

  function automatic logic [31:0] be_merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk_125) begin
    for (int c = 0; c < NCH; c++) begin
      for (int k = RD_LAT - 1; k > 0; k--) pipe[c][k] <= pipe[c][k-1];
      pipe[c][0] <= mem[c][ram_addr_o[c*RAM_AW +: RAM_AW]];
      if (ram_we_o[c])
        mem[c][ram_addr_o[c*RAM_AW +: RAM_AW]] <=
          be_merge(mem[c][ram_addr_o[c*RAM_AW +: RAM_AW]], ram_data_o[c*32 +: 32], ram_be_o[c*4 +: 4]);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_q
    assign ram_q_i[g*32 +: 32] = pipe[g][RD_LAT-1];
  end

  // Reference model state
  logic [31:0]    exp_mem [int];
  logic [NCH-1:0] exp_status = '0;
  logic [NCH-1:0] exp_mask = '0;
  logic [31:0]    exp_hold = '0;

  function automatic logic [31:0] mem_get(int c, int w);
    int key = c * 4096 + w;
    return exp_mem.exists(key) ? exp_mem[key] : 32'h0;
  endfunction

  // sel[1] carries data[7:0], sel[0] carries data[15:8]; hi selects the upper half-word.
  function automatic logic [31:0] lane_write(logic [31:0] old, logic [15:0] d, logic [1:0] sel, logic hi);
    logic [31:0] r = old;
    int sh = hi ? 16 : 0;
    if (sel[1]) r[sh +: 8] = d[7:0];
    if (sel[0]) r[sh+8 +: 8] = d[15:8];
    return r;
  endfunction

  function automatic logic [15:0] slot_adr(int c, int w, logic hi);
    return {3'(c + 1), 11'(w), hi, 1'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer; rdy is pulsed on slot_ready_i in the request cycle.
  // Waits one extra cycle after ack so single-cycle ack and delayed irq can be seen.
  task automatic applyStimulus(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                               input logic [1:0] sel, input logic [NCH-1:0] rdy,
                               output logic [15:0] rdata, output int lat);
    logic ok = 1'b0;
    @(negedge clk_125);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; slot_ready_i = rdy;
    lat = 0;
    rdata = 'x;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_125); #1;
      slot_ready_i = '0;
      lat++;
      if (wb_ack_o === 1'b1) begin
        ok = 1'b1;
        rdata = wb_dat_o; we_snap = ram_we_o; addr_snap = ram_addr_o;
        be_snap = ram_be_o; data_snap = ram_data_o;
        rst_snap = global_counter_rst_o; irq_snap = irq_n_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!ok) checkOutput("ack_timeout", 0, 1);
    else begin
      @(posedge clk_125); #1;
      checkOutput("ack_single_cycle", wb_ack_o, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0]    rd, d, d2;
    logic [1:0]     s, s2;
    logic [NCH-1:0] r, r2, m, oh;
    logic [63:0]    cnt;
    logic [31:0]    h;
    int             lat, c, w, acks;

    for (int cc = 0; cc < NCH; cc++) begin
      for (int a = 0; a < 2**RAM_AW; a++) mem[cc][a] = 32'h0;
      for (int k = 0; k < RD_LAT; k++) pipe[cc][k] = 32'h0;
    end
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
    slot_ready_i = '0; global_counter_i = '0;

    // Reset values
    repeat (3) @(posedge clk_125); #1;
    checkOutput("rst_irq_n", irq_n_o, 1);
    checkOutput("rst_ack", wb_ack_o, 0);
    checkOutput("rst_dat", wb_dat_o, 0);
    checkOutput("rst_cnt_rst", global_counter_rst_o, 0);
    checkOutput("rst_ram_we", ram_we_o, 0);
    checkOutput("rst_ram_addr", ram_addr_o, 0);
    @(negedge clk_125); rstn = 1'b1;

    applyStimulus(0, 16'h0000, 0, 2'b11, '0, rd, lat);
    checkOutput("status_rd_lat", lat, 1);
    checkOutput("status_rd_dat", rd, 0);
    checkOutput("irq_idle", irq_n_o, 1);

    // Set-wins-over-W1C, then a lone W1C
    applyStimulus(0, 16'h0002, 0, 2'b11, 2'b10, rd, lat);
    checkOutput("mask_rd0", rd, 0);
    exp_status = 2'b10;
    applyStimulus(1, 16'h0002, 16'h0002, 2'b11, '0, rd, lat);
    exp_mask = 2'b10;
    checkOutput("irq_after_mask", irq_n_o, 0);
    applyStimulus(1, 16'h0000, 16'h0002, 2'b11, 2'b10, rd, lat);
    applyStimulus(0, 16'h0000, 0, 2'b11, '0, rd, lat);
    checkOutput("set_wins_status", rd, 16'h0002);
    checkOutput("set_wins_irq", irq_n_o, 0);
    applyStimulus(1, 16'h0000, 16'h0002, 2'b11, '0, rd, lat);
    exp_status = '0;
    checkOutput("w1c_irq_at_ack", irq_snap, 0);
    checkOutput("w1c_irq_later", irq_n_o, 1);

    // Randomized status / mask / W1C traffic
    for (int i = 0; i < 6; i++) begin
      r = NCH'($urandom); m = NCH'($urandom); r2 = NCH'($urandom);
      d = 16'($urandom); s = 2'($urandom); s2 = 2'($urandom);
      applyStimulus(0, 16'h0002, 0, 2'b11, r, rd, lat);
      checkOutput("rnd_mask_rd", rd, 16'(exp_mask));
      exp_status = exp_status | r;
      applyStimulus(1, 16'h0002, {d[15:NCH], m}, s, '0, rd, lat);
      if (s[1]) exp_mask = m;
      applyStimulus(1, 16'h0000, d, s2, r2, rd, lat);
      if (s2[1]) exp_status = exp_status & ~d[NCH-1:0];
      exp_status = exp_status | r2;
      applyStimulus(0, 16'h0000, 0, 2'b11, '0, rd, lat);
      checkOutput("rnd_status_rd", rd, 16'(exp_status));
      checkOutput("rnd_irq", irq_n_o, ~|(exp_status & exp_mask));
    end

    // Unmapped global words return 0 even with status set
    applyStimulus(0, 16'h000E, 0, 2'b11, '1, rd, lat);
    exp_status = '1;
    checkOutput("glob_idx7_rd", rd, 0);
    applyStimulus(0, 16'h0010, 0, 2'b11, '0, rd, lat);
    checkOutput("glob_row1_rd", rd, 0);
    applyStimulus(0, 16'h0000, 0, 2'b11, '0, rd, lat);
    checkOutput("status_all_set", rd, 16'(exp_status));
    applyStimulus(1, 16'h0000, 16'hFFFF, 2'b11, '0, rd, lat);
    exp_status = '0;

    // Counter snapshot
    global_counter_i = 64'h1111_2222_3333_4444;
    applyStimulus(0, 16'h0004, 0, 2'b11, '0, rd, lat);
    checkOutput("snap_w0", rd, 16'h4444);
    global_counter_i = {$urandom, $urandom};
    applyStimulus(0, 16'h0006, 0, 2'b11, '0, rd, lat);
    checkOutput("snap_w1", rd, 16'h3333);
    applyStimulus(0, 16'h0008, 0, 2'b11, '0, rd, lat);
    checkOutput("snap_w2", rd, 16'h2222);
    applyStimulus(0, 16'h000A, 0, 2'b11, '0, rd, lat);
    checkOutput("snap_w3", rd, 16'h1111);
    cnt = {$urandom, $urandom};
    global_counter_i = cnt;
    applyStimulus(0, 16'h0004, 0, 2'b11, '0, rd, lat);
    checkOutput("snap_rnd_w0", rd, cnt[15:0]);
    global_counter_i = ~cnt;
    applyStimulus(0, 16'h000A, 0, 2'b11, '0, rd, lat);
    checkOutput("snap_rnd_w3", rd, cnt[63:48]);

    // Counter clear pulse
    applyStimulus(1, 16'h000C, 16'h0001, 2'b11, '0, rd, lat);
    checkOutput("cnt_rst_pulse", rst_snap, 1);
    checkOutput("cnt_rst_one_cycle", global_counter_rst_o, 0);
    applyStimulus(1, 16'h000C, 16'hFFFE, 2'b11, '0, rd, lat);
    checkOutput("cnt_rst_bit0_clear", rst_snap, 0);
    applyStimulus(0, 16'h000C, 0, 2'b11, '0, rd, lat);
    checkOutput("cnt_rst_rd", rd, 0);

    // Directed slot writes / reads on channel 1
    applyStimulus(1, 16'h4000, 16'hBEEF, 2'b11, '0, rd, lat);
    checkOutput("wr_lo_we", we_snap, 2'b10);
    checkOutput("wr_lo_addr", addr_snap[RAM_AW +: RAM_AW], 0);
    checkOutput("wr_lo_be", be_snap[7:4], 4'b0011);
    checkOutput("wr_lo_data", data_snap[47:32], 16'hBEEF);
    exp_mem[4096] = lane_write(mem_get(1, 0), 16'hBEEF, 2'b11, 1'b0);
    applyStimulus(1, 16'h4002, 16'hDEAD, 2'b11, '0, rd, lat);
    checkOutput("wr_hi_be", be_snap[7:4], 4'b1100);
    checkOutput("wr_hi_data", data_snap[63:48], 16'hDEAD);
    exp_mem[4096] = lane_write(mem_get(1, 0), 16'hDEAD, 2'b11, 1'b1);
    checkOutput("ram_word", mem[1][0], 32'hDEADBEEF);
    applyStimulus(0, 16'h4000, 0, 2'b11, '0, rd, lat);
    checkOutput("rd_lo_lat", lat, RD_LAT + 1);
    checkOutput("rd_lo_dat", rd, 16'hBEEF);
    exp_hold = mem_get(1, 0);
    applyStimulus(0, 16'h4002, 0, 2'b11, '0, rd, lat);
    checkOutput("rd_hi_lat", lat, 1);
    checkOutput("rd_hi_dat", rd, 16'hDEAD);
    applyStimulus(1, 16'h4000, 16'h1234, 2'b10, '0, rd, lat);
    checkOutput("lane_sel10_be", be_snap[7:4], 4'b0001);
    exp_mem[4096] = lane_write(mem_get(1, 0), 16'h1234, 2'b10, 1'b0);
    applyStimulus(0, 16'h4000, 0, 2'b11, '0, rd, lat);
    checkOutput("lane_sel10_rd", rd, 16'hBE34);
    exp_hold = mem_get(1, 0);

    // Randomized slot traffic
    for (int i = 0; i < 8; i++) begin
      c = $urandom_range(0, NCH - 1);
      w = $urandom_range(0, 2**RAM_AW - 1);
      d = 16'($urandom); d2 = 16'($urandom); s = 2'($urandom); s2 = 2'($urandom);
      oh = '0; oh[c] = 1'b1;
      applyStimulus(1, slot_adr(c, w, 1'b0), d, s, '0, rd, lat);
      checkOutput("rnd_wr_we", we_snap, oh);
      checkOutput("rnd_wr_addr", addr_snap[c*RAM_AW +: RAM_AW], w);
      exp_mem[c*4096 + w] = lane_write(mem_get(c, w), d, s, 1'b0);
      applyStimulus(1, slot_adr(c, w, 1'b1), d2, s2, '0, rd, lat);
      exp_mem[c*4096 + w] = lane_write(mem_get(c, w), d2, s2, 1'b1);
      applyStimulus(0, slot_adr(c, w, 1'b0), 0, 2'b11, '0, rd, lat);
      checkOutput("rnd_rd_lo_lat", lat, RD_LAT + 1);
      checkOutput("rnd_rd_lo_dat", rd, mem_get(c, w) & 32'hFFFF);
      exp_hold = mem_get(c, w);
      applyStimulus(0, slot_adr(c, w, 1'b1), 0, 2'b11, '0, rd, lat);
      checkOutput("rnd_rd_hi_dat", rd, exp_hold[31:16]);
    end

    // Abort during RD_WAIT: no ack, hold untouched, FSM back in IDLE
    h = exp_hold;
    applyStimulus(1, slot_adr(0, 5, 1'b0), 16'h5A5A, 2'b11, '0, rd, lat);
    applyStimulus(1, slot_adr(0, 5, 1'b1), ~h[31:16], 2'b11, '0, rd, lat);
    @(negedge clk_125);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = slot_adr(0, 5, 1'b0);
    @(posedge clk_125);
    @(negedge clk_125);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acks = 0;
    repeat (5) begin
      @(posedge clk_125); #1;
      if (wb_ack_o) acks++;
    end
    checkOutput("abort_no_ack", acks, 0);
    applyStimulus(0, slot_adr(0, 5, 1'b1), 0, 2'b11, '0, rd, lat);
    checkOutput("abort_hold_kept", rd, h[31:16]);
    applyStimulus(0, 16'h0002, 0, 2'b11, '0, rd, lat);
    checkOutput("abort_idle_lat", lat, 1);

    // Unmapped regions
    applyStimulus(1, 16'hE000, 16'($urandom), 2'b11, '0, rd, lat);
    checkOutput("reg7_wr_lat", lat, 1);
    checkOutput("reg7_no_we", we_snap, 0);
    applyStimulus(0, 16'hE000, 0, 2'b11, '0, rd, lat);
    checkOutput("reg7_rd", rd, 0);
    applyStimulus(0, 16'h6000, 0, 2'b11, '0, rd, lat);
    checkOutput("reg3_rd_lat", lat, 1);
    checkOutput("reg3_rd", rd, 0);

    // Reset in the middle of a pending slot read
    applyStimulus(1, 16'h0002, 16'h0003, 2'b11, '0, rd, lat);
    @(negedge clk_125);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h4000;
    @(posedge clk_125); #1;
    rstn = 1'b0;
    #1;
    acks = 0;
    repeat (4) begin
      @(posedge clk_125); #1;
      if (wb_ack_o) acks++;
    end
    checkOutput("midrst_no_ack", acks, 0);
    checkOutput("midrst_irq_n", irq_n_o, 1);
    checkOutput("midrst_ram_addr", ram_addr_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk_125); rstn = 1'b1;
    exp_mask = '0; exp_status = '0; exp_hold = '0;
    applyStimulus(0, 16'h0002, 0, 2'b11, '0, rd, lat);
    checkOutput("midrst_mask", rd, 16'(exp_mask));
    applyStimulus(0, 16'h4002, 0, 2'b11, '0, rd, lat);
    checkOutput("midrst_hold", rd, exp_hold[31:16]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
